// File: rtl/lap_memory_pkg.sv
// -----------------------------------------------------------------------------
// lap_memory_pkg
// Shared constants and types for the stopwatch lap memory.
//   LAP_DEPTH / BCD_DIGITS / TIME_W : default buffer depth and time-word geometry
//   lap_mode_e                      : display mode encoding (live count / stored lap)
//   lap_ptr_w()                     : pointer width for a given power-of-two depth
// -----------------------------------------------------------------------------
package lap_memory_pkg;

    localparam int LAP_DEPTH  = 8;
    localparam int BCD_DIGITS = 8;
    localparam int TIME_W     = 4 * BCD_DIGITS;

    typedef enum logic {
        MODE_LIVE   = 1'b0,
        MODE_RECALL = 1'b1
    } lap_mode_e;

    // Number of bits needed to index 'depth' entries (depth is a power of two, >= 2).
    function automatic int lap_ptr_w(input int depth);
        int w;
        w = 0;
        while ((32'sd1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lap_memory_rise_edge.sv
// -----------------------------------------------------------------------------
// rise_edge
// Turns a debounced key level into a single-cycle event on its rising edge.
// The previous level is held in a register; the event is asserted while the
// current level is high and the stored previous level is low, so a held key
// produces exactly one event.
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset (clears the level history)
//   level : debounced key level, 1 = pressed
//   pulse : one-cycle event on a 0->1 transition of level
// -----------------------------------------------------------------------------
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_r;

    // Level history register, keeps running through the lap-buffer clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= 1'b0;
        end else begin
            level_r <= level;
        end
    end

    assign pulse = level & ~level_r;

endmodule

// File: rtl/lap_memory.sv
// -----------------------------------------------------------------------------
// lap_memory
// Captures lap times from the running BCD count into a small circular buffer
// and lets the user step through them on the display without stopping the count.
//
// Parameters
//   DEPTH  : number of lap entries (power of two, 2..16)
//   DIGITS : BCD digits per time word, data width 4*DIGITS
// Ports
//   clk, rst    : clock and synchronous active-high reset
//   count       : live BCD time, treated as opaque data
//   lap_key     : debounced lap key level
//   recall_key  : debounced recall key level
//   clear       : synchronous, level-sensitive clear of the lap buffer
//   display     : registered time word for the display path
//   recall_mode : 1 while a stored lap is shown
//   recall_idx  : shown lap, relative to the oldest entry
//   lap_count   : number of valid entries, 0..DEPTH
//   full        : lap_count == DEPTH
//   overflow    : sticky, a lap press arrived while the buffer was full
//
// Build option
//   LAP_OVERWRITE_EN : when defined, a lap while full overwrites the oldest
//                      entry instead of being rejected (overflow still set).
// -----------------------------------------------------------------------------
module lap_memory
    import lap_memory_pkg::*;
#(
    parameter int DEPTH  = LAP_DEPTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*DIGITS-1:0]           count,
    input  logic                          lap_key,
    input  logic                          recall_key,
    input  logic                          clear,
    output logic [4*DIGITS-1:0]           display,
    output logic                          recall_mode,
    output logic [lap_ptr_w(DEPTH)-1:0]   recall_idx,
    output logic [lap_ptr_w(DEPTH):0]     lap_count,
    output logic                          full,
    output logic                          overflow
);

    localparam int TW    = 4 * DIGITS;
    localparam int PTR_W = lap_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             lap_ev_s;
    logic             recall_ev_s;

    lap_mode_e        mode_r;
    logic [PTR_W-1:0] recall_idx_r;
    logic [CNT_W-1:0] lap_count_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_base_r;
    logic             overflow_r;
    logic [TW-1:0]    display_r;
    logic [TW-1:0]    lap_buf_r [DEPTH];

    lap_mode_e        mode_nxt_s;
    logic [PTR_W-1:0] idx_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [PTR_W-1:0] wr_nxt_s;
    logic [PTR_W-1:0] rd_nxt_s;
    logic             ovf_nxt_s;
    logic             wr_en_s;
    logic             full_s;
    logic [PTR_W-1:0] rd_idx_s;
    logic [TW-1:0]    rd_data_s;
    logic [TW-1:0]    disp_nxt_s;

    rise_edge u_lap_edge (
        .clk   (clk),
        .rst   (rst),
        .level (lap_key),
        .pulse (lap_ev_s)
    );

    rise_edge u_recall_edge (
        .clk   (clk),
        .rst   (rst),
        .level (recall_key),
        .pulse (recall_ev_s)
    );

    assign full_s = (lap_count_r == CNT_W'(DEPTH));

    // Next-state for mode, recall index, pointers, count and overflow.
    always_comb begin
        mode_nxt_s = mode_r;
        idx_nxt_s  = recall_idx_r;
        cnt_nxt_s  = lap_count_r;
        wr_nxt_s   = wr_ptr_r;
        rd_nxt_s   = rd_base_r;
        ovf_nxt_s  = overflow_r;
        wr_en_s    = 1'b0;
        if (clear) begin
            // Clear wins over both key events in the same cycle.
            mode_nxt_s = MODE_LIVE;
            idx_nxt_s  = {PTR_W{1'b0}};
            cnt_nxt_s  = {CNT_W{1'b0}};
            wr_nxt_s   = {PTR_W{1'b0}};
            rd_nxt_s   = {PTR_W{1'b0}};
            ovf_nxt_s  = 1'b0;
        end else begin
            if (lap_ev_s) begin
                if (!full_s) begin
                    wr_en_s   = 1'b1;
                    wr_nxt_s  = wr_ptr_r + PTR_W'(1);
                    cnt_nxt_s = lap_count_r + CNT_W'(1);
                end else begin
`ifdef LAP_OVERWRITE_EN
                    // Full: drop the oldest entry, the write slot is the oldest slot.
                    wr_en_s  = 1'b1;
                    wr_nxt_s = wr_ptr_r + PTR_W'(1);
                    rd_nxt_s = rd_base_r + PTR_W'(1);
`endif
                    ovf_nxt_s = 1'b1;
                end
            end else begin
                wr_en_s = 1'b0;
            end
            // Recall decisions look at the entry count before any capture this cycle.
            if (recall_ev_s) begin
                case (mode_r)
                    MODE_LIVE: begin
                        if (lap_count_r != {CNT_W{1'b0}}) begin
                            mode_nxt_s = MODE_RECALL;
                            idx_nxt_s  = {PTR_W{1'b0}};
                        end else begin
                            mode_nxt_s = MODE_LIVE;
                        end
                    end
                    MODE_RECALL: begin
                        if (({1'b0, recall_idx_r} + CNT_W'(1)) < lap_count_r) begin
                            idx_nxt_s = recall_idx_r + PTR_W'(1);
                        end else begin
                            mode_nxt_s = MODE_LIVE;
                            idx_nxt_s  = {PTR_W{1'b0}};
                        end
                    end
                    default: begin
                        mode_nxt_s = MODE_LIVE;
                        idx_nxt_s  = {PTR_W{1'b0}};
                    end
                endcase
            end else begin
                mode_nxt_s = mode_r;
            end
        end
    end

    // Display source: live count, or the selected lap with a bypass for the
    // slot being overwritten in this same cycle.
    always_comb begin
        rd_idx_s = rd_nxt_s + idx_nxt_s;
        if (wr_en_s && (rd_idx_s == wr_ptr_r)) begin
            rd_data_s = count;
        end else begin
            rd_data_s = lap_buf_r[rd_idx_s];
        end
        if (mode_nxt_s == MODE_RECALL) begin
            disp_nxt_s = rd_data_s;
        end else begin
            disp_nxt_s = count;
        end
    end

    // Control state and registered display word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r       <= MODE_LIVE;
            recall_idx_r <= {PTR_W{1'b0}};
            lap_count_r  <= {CNT_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_base_r    <= {PTR_W{1'b0}};
            overflow_r   <= 1'b0;
            display_r    <= {TW{1'b0}};
        end else begin
            mode_r       <= mode_nxt_s;
            recall_idx_r <= idx_nxt_s;
            lap_count_r  <= cnt_nxt_s;
            wr_ptr_r     <= wr_nxt_s;
            rd_base_r    <= rd_nxt_s;
            overflow_r   <= ovf_nxt_s;
            display_r    <= disp_nxt_s;
        end
    end

    // Lap storage; contents are not reset, validity is tracked by lap_count.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            lap_buf_r[wr_ptr_r] <= count;
        end else begin
            lap_buf_r[wr_ptr_r] <= lap_buf_r[wr_ptr_r];
        end
    end

    assign display     = display_r;
    assign recall_mode = (mode_r == MODE_RECALL);
    assign recall_idx  = recall_idx_r;
    assign lap_count   = lap_count_r;
    assign full        = full_s;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_lap_memory.sv
// -----------------------------------------------------------------------------
// tb_lap_memory
// Directed bench for lap_memory with default DEPTH=8, DIGITS=8. Expected values
// are written by hand from the intended behaviour. Builds with LAP_OVERWRITE_EN
// switch the expectations for the full-buffer scenario.
// -----------------------------------------------------------------------------
module tb_lap_memory;

    logic        clk;
    logic        rst;
    logic [31:0] count;
    logic        lap_key;
    logic        recall_key;
    logic        clear;
    logic [31:0] display;
    logic        recall_mode;
    logic [2:0]  recall_idx;
    logic [3:0]  lap_count;
    logic        full;
    logic        overflow;

    int n_checks;
    int n_fail;

    lap_memory dut (
        .clk         (clk),
        .rst         (rst),
        .count       (count),
        .lap_key     (lap_key),
        .recall_key  (recall_key),
        .clear       (clear),
        .display     (display),
        .recall_mode (recall_mode),
        .recall_idx  (recall_idx),
        .lap_count   (lap_count),
        .full        (full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock, then settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_lap(input logic [31:0] val, input int hold);
        count   = val;
        lap_key = 1'b1;
        repeat (hold) tick();
        lap_key = 1'b0;
        tick();
    endtask

    task automatic press_recall();
        recall_key = 1'b1;
        repeat (2) tick();
        recall_key = 1'b0;
        tick();
    endtask

    logic [31:0] exp_v;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        count      = 32'h0000_0000;
        lap_key    = 1'b0;
        recall_key = 1'b0;
        clear      = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_display",  display,     32'h0);
        check_eq("rst_mode",     recall_mode, 32'h0);
        check_eq("rst_idx",      recall_idx,  32'h0);
        check_eq("rst_count",    lap_count,   32'h0);
        check_eq("rst_full",     full,        32'h0);
        check_eq("rst_overflow", overflow,    32'h0);

        // Live display, one cycle of latency
        count = 32'h0001_2345;
        tick();
        check_eq("live_display", display,     32'h0001_2345);
        check_eq("live_count",   lap_count,   32'h0);
        check_eq("live_mode",    recall_mode, 32'h0);

        // Three held lap presses, one entry each
        press_lap(32'h0000_0100, 5);
        press_lap(32'h0000_0250, 5);
        press_lap(32'h0000_0399, 5);
        check_eq("three_laps", lap_count, 32'd3);
        count = 32'h0000_9999;
        press_recall();
        check_eq("rc1_mode", recall_mode, 32'h1);
        check_eq("rc1_disp", display,     32'h0000_0100);
        press_recall();
        check_eq("rc2_disp", display,     32'h0000_0250);
        check_eq("rc2_idx",  recall_idx,  32'd1);
        press_recall();
        check_eq("rc3_disp", display,     32'h0000_0399);
        press_recall();
        check_eq("rc4_mode", recall_mode, 32'h0);
        count = 32'h0000_0777;
        tick();
        check_eq("rc4_live", display, 32'h0000_0777);

        // Nine laps into an eight-entry buffer
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_count", lap_count, 32'h0);
        for (int i = 0; i < 8; i++) press_lap(32'h0000_1000 + i, 2);
        check_eq("eight_full", full,     32'h1);
        check_eq("eight_ovf",  overflow, 32'h0);
        press_lap(32'h0000_1008, 2);
        check_eq("nine_count", lap_count, 32'd8);
        check_eq("nine_full",  full,      32'h1);
        check_eq("nine_ovf",   overflow,  32'h1);
        count = 32'h0000_5555;
        for (int i = 0; i < 8; i++) begin
`ifdef LAP_OVERWRITE_EN
            exp_v = 32'h0000_1001 + i;
`else
            exp_v = 32'h0000_1000 + i;
`endif
            press_recall();
            check_eq($sformatf("full_entry%0d", i), display, exp_v);
        end
        press_recall();
        check_eq("full_exit", recall_mode, 32'h0);

        // Clear in RECALL at idx 1 while lap_key rises and stays held
        press_recall();
        press_recall();
        check_eq("pre_clr_idx", recall_idx, 32'd1);
        clear   = 1'b1;
        lap_key = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_count2", lap_count,   32'h0);
        check_eq("clr_mode",   recall_mode, 32'h0);
        check_eq("clr_ovf",    overflow,    32'h0);
        repeat (3) tick();
        check_eq("held_no_ev", lap_count, 32'h0);
        lap_key = 1'b0;
        tick();
        press_lap(32'h0000_0042, 2);
        check_eq("repress", lap_count, 32'd1);

        // Simultaneous lap and recall events
        clear = 1'b1;
        tick();
        clear      = 1'b0;
        count      = 32'h0000_00A1;
        lap_key    = 1'b1;
        recall_key = 1'b1;
        tick();
        lap_key    = 1'b0;
        recall_key = 1'b0;
        tick();
        check_eq("sim1_count", lap_count,   32'd1);
        check_eq("sim1_mode",  recall_mode, 32'h0);
        count      = 32'h0000_00A2;
        lap_key    = 1'b1;
        recall_key = 1'b1;
        tick();
        lap_key    = 1'b0;
        recall_key = 1'b0;
        tick();
        check_eq("sim2_count", lap_count,   32'd2);
        check_eq("sim2_mode",  recall_mode, 32'h1);
        check_eq("sim2_idx",   recall_idx,  32'h0);
        check_eq("sim2_disp",  display,     32'h0000_00A1);
        press_recall();
        check_eq("sim2_next", display, 32'h0000_00A2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
